// File: rtl/dlc_omi_rx_bist_ctl.sv
// Receive-side link BIST sequencer: holds the per-lane PRBS7 checkers in reset, lets them settle,
// opens a check window, then reports per-lane fail mask, pass flag and the first error cycle.
module dlc_omi_rx_bist_ctl #(
    parameter int LANES  = 8,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 16
) (
    input  logic             phy_dl_clock,
    input  logic             omi_reset_n,
    input  logic             omi_enable,
    input  logic             bist_start,
    input  logic             bist_abort,
    input  logic [CNT_W-1:0] bist_window,
    input  logic [LANES-1:0] lane_mask,
    input  logic [LANES-1:0] prbs_error_in,
    output logic [LANES-1:0] rx_bist_reset,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_pass,
    output logic [LANES-1:0] bist_fail_lanes,
    output logic             bist_err_seen,
    output logic [CNT_W-1:0] bist_first_err_cnt,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [7:0]       settle_q, settle_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             drain_q, drain_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [LANES-1:0] fail_q, fail_d;
    logic             err_seen_q, err_seen_d;
    logic [CNT_W-1:0] first_q, first_d;

    logic [LANES-1:0] err_masked;
    logic             capture_ok;

    assign err_masked = prbs_error_in & mask_q;
    // The first RUN cycle is skipped: the checker is still clearing its sticky error then.
    assign capture_ok = (state_q == S_DRAIN) || ((state_q == S_RUN) && (run_cnt_q != '0));

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        win_d      = win_q;
        settle_d   = settle_q;
        run_cnt_d  = run_cnt_q;
        drain_d    = drain_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_d     = fail_q;
        err_seen_d = err_seen_q;
        first_d    = first_q;

        if (bist_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bist_start) begin
                        mask_d     = lane_mask;
                        win_d      = (bist_window == '0) ? CNT_ONE : bist_window;
                        fail_d     = '0;
                        pass_d     = 1'b0;
                        err_seen_d = 1'b0;
                        first_d    = '0;
                        settle_d   = '0;
                        run_cnt_d  = '0;
                        if (lane_mask != '0) begin
                            state_d = S_SYNC;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                S_SYNC: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d   = S_RUN;
                        run_cnt_d = '0;
                    end else begin
                        settle_d = settle_q + 8'd1;
                    end
                end
                S_RUN, S_DRAIN: begin
                    run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CNT_ONE;
                    if (capture_ok && !err_seen_q && (err_masked != '0)) begin
                        err_seen_d = 1'b1;
                        first_d    = run_cnt_q;
                    end
                    if (state_q == S_RUN) begin
                        if (run_cnt_q == win_q - CNT_ONE) begin
                            state_d = S_DRAIN;
                            drain_d = 1'b0;
                        end
                    end else if (drain_q) begin
                        // Results are registered on entry to DONE so they are valid with the done pulse.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        fail_d  = err_masked;
                        pass_d  = (mask_q != '0) && (err_masked == '0);
                    end else begin
                        drain_d = 1'b1;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge phy_dl_clock or negedge omi_reset_n) begin
        if (!omi_reset_n) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            win_q      <= CNT_ONE;
            settle_q   <= '0;
            run_cnt_q  <= '0;
            drain_q    <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= '0;
            err_seen_q <= 1'b0;
            first_q    <= '0;
        end else if (omi_enable) begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            win_q      <= win_d;
            settle_q   <= settle_d;
            run_cnt_q  <= run_cnt_d;
            drain_q    <= drain_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            err_seen_q <= err_seen_d;
            first_q    <= first_d;
        end
    end

    assign rx_bist_reset      = ((state_q == S_RUN) || (state_q == S_DRAIN)) ? ~mask_q : '1;
    assign bist_busy          = (state_q == S_SYNC) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bist_done          = done_q;
    assign bist_pass          = pass_q;
    assign bist_fail_lanes    = fail_q;
    assign bist_err_seen      = err_seen_q;
    assign bist_first_err_cnt = first_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_dlc_omi_rx_bist_ctl.sv
// Directed bench for dlc_omi_rx_bist_ctl: start requests push expected results into a queue,
// a monitor pops and compares them whenever bist_done pulses.
module tb_dlc_omi_rx_bist_ctl;

    localparam int SETTLE = 16;

    // Valid/ready contract: bist_start is a one-cycle request honoured only in IDLE;
    // bist_done is a one-cycle pulse and results are valid during that cycle.

    typedef struct packed {
        logic [31:0] cyc;
        logic        pass;
        logic [7:0]  fail;
        logic        err;
        logic [15:0] first;
    } exp_t;

    exp_t exp_q[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] win = '0;
    logic [7:0]  mask = '0;
    logic [7:0]  perr = '0;
    logic [7:0]  rx_rst;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  fail;
    logic        err_seen;
    logic [15:0] first_err;
    logic [2:0]  dbg_state;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int t;
    int r;

    dlc_omi_rx_bist_ctl #(.LANES(8), .CNT_W(16), .SETTLE(SETTLE)) dut (
        .phy_dl_clock       (clk),
        .omi_reset_n        (rst_n),
        .omi_enable         (en),
        .bist_start         (start),
        .bist_abort         (abort),
        .bist_window        (win),
        .lane_mask          (mask),
        .prbs_error_in      (perr),
        .rx_bist_reset      (rx_rst),
        .bist_busy          (busy),
        .bist_done          (done),
        .bist_pass          (pass),
        .bist_fail_lanes    (fail),
        .bist_err_seen      (err_seen),
        .bist_first_err_cnt (first_err),
        .dbg_state_o        (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Driver: issue a start at the current negedge and push the hand-derived result.
    task automatic start_run(input logic [7:0] m, input logic [15:0] w, input logic exp_done,
                             input logic e_pass, input logic [7:0] e_fail, input logic e_err,
                             input logic [15:0] e_first, input int stretch, output int t0);
        exp_t e;
        int   wl;
        t0 = cyc;
        wl = (w == 16'd0) ? 1 : int'(w);
        mask = m;
        win = w;
        start = 1'b1;
        e.cyc   = (m == 8'd0) ? 32'(t0 + 1) : 32'(t0 + 1 + SETTLE + wl + 2 + stretch);
        e.pass  = e_pass;
        e.fail  = e_fail;
        e.err   = e_err;
        e.first = e_first;
        if (exp_done) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        mask = 8'($urandom_range(0, 255));
        win = 16'($urandom_range(0, 65535));
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected no done", cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), e.cyc);
                check("pass", {31'd0, pass}, {31'd0, e.pass});
                check("fail_lanes", {24'd0, fail}, {24'd0, e.fail});
                check("err_seen", {31'd0, err_seen}, {31'd0, e.err});
                check("first_err_cnt", {16'd0, first_err}, {16'd0, e.first});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rx_bist_reset", {24'd0, rx_rst}, 32'hFF);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_pass", {31'd0, pass}, 0);
        check("rst_fail", {24'd0, fail}, 0);
        check("rst_err_seen", {31'd0, err_seen}, 0);
        check("rst_first", {16'd0, first_err}, 0);
        check("rst_state", {29'd0, dbg_state}, 0);
        rst_n = 1'b1;

        // Clean run, all lanes, window 100, start at cycle 10
        wait_to(10);
        start_run(8'hFF, 16'd100, 1'b1, 1'b1, 8'h00, 1'b0, 16'd0, 0, t);
        wait_to(26);
        check("sync_rx_held", {24'd0, rx_rst}, 32'hFF);
        check("sync_busy", {31'd0, busy}, 1);
        wait_to(27);
        check("run_first_rx", {24'd0, rx_rst}, 32'h00);
        wait_to(40);
        mask = 8'h00;
        win = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(128);
        check("drain_last_rx", {24'd0, rx_rst}, 32'h00);
        wait_to(129);
        check("done_rx_held", {24'd0, rx_rst}, 32'hFF);
        wait_to(131);
        check("idle_busy", {31'd0, busy}, 0);

        // Lane 3 error appearing at run_cnt 41
        wait_to(135);
        start_run(8'hFF, 16'd100, 1'b1, 1'b0, 8'h08, 1'b1, 16'd41, 0, t);
        r = t + 1 + SETTLE;
        wait_to(r + 41);
        perr = 8'h08;
        wait_to(r + 104);
        perr = 8'h00;

        // Lanes 4-7 masked and fed garbage
        start_run(8'h0F, 16'd20, 1'b1, 1'b1, 8'h00, 1'b0, 16'd0, 0, t);
        perr = 8'hA0;
        r = t + 1 + SETTLE;
        wait_to(r + 3);
        check("masked_rx_run", {24'd0, rx_rst}, 32'hF0);
        perr = 8'h50;
        wait_to(r + 10);
        perr = 8'hF0;
        wait_to(r + 21);
        check("masked_rx_drain", {24'd0, rx_rst}, 32'hF0);
        wait_to(r + 25);
        perr = 8'h00;

        // Abort at RUN cycle 50 after an error at run_cnt 10
        start_run(8'hFF, 16'd100, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 0, t);
        r = t + 1 + SETTLE;
        wait_to(r + 10);
        perr = 8'h02;
        wait_to(r + 50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_rx", {24'd0, rx_rst}, 32'hFF);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_err_kept", {31'd0, err_seen}, 1);
        check("abort_first_kept", {16'd0, first_err}, 10);
        check("abort_pass_kept", {31'd0, pass}, 0);
        perr = 8'h00;
        repeat (3) @(negedge clk);
        start_run(8'h3C, 16'd5, 1'b1, 1'b1, 8'h00, 1'b0, 16'd0, 0, t);
        wait_to(t + 30);

        // Window 0 behaves as 1 RUN cycle
        start_run(8'h01, 16'd0, 1'b1, 1'b1, 8'h00, 1'b0, 16'd0, 0, t);
        r = t + 1 + SETTLE;
        wait_to(r);
        check("win0_run_rx", {24'd0, rx_rst}, 32'hFE);
        wait_to(r + 2);
        check("win0_drain_rx", {24'd0, rx_rst}, 32'hFE);
        wait_to(r + 3);
        check("win0_done_rx", {24'd0, rx_rst}, 32'hFF);
        wait_to(r + 6);

        // Empty mask goes straight to DONE
        start_run(8'h00, 16'd50, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 0, t);
        check("mask0_busy", {31'd0, busy}, 0);
        wait_to(t + 4);

        // Enable held low for 5 cycles mid-SYNC stretches done by 5
        start_run(8'hFF, 16'd10, 1'b1, 1'b1, 8'h00, 1'b0, 16'd0, 5, t);
        wait_to(t + 5);
        en = 1'b0;
        wait_to(t + 10);
        en = 1'b1;
        wait_to(t + 40);

        // Asynchronous reset pulse mid-RUN
        start_run(8'hFF, 16'd100, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 0, t);
        r = t + 1 + SETTLE;
        wait_to(r + 5);
        perr = 8'h04;
        wait_to(r + 20);
        check("pre_reset_err_seen", {31'd0, err_seen}, 1);
        check("pre_reset_busy", {31'd0, busy}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rx", {24'd0, rx_rst}, 32'hFF);
        check("async_rst_busy", {31'd0, busy}, 0);
        check("async_rst_err_seen", {31'd0, err_seen}, 0);
        check("async_rst_first", {16'd0, first_err}, 0);
        check("async_rst_state", {29'd0, dbg_state}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        perr = 8'h00;
        @(negedge clk);
        start_run(8'hFF, 16'd4, 1'b1, 1'b1, 8'h00, 1'b0, 16'd0, 0, t);
        wait_to(t + 30);

        check("pending_done", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
